// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and helpers for the instruction-memory loader.
//   - ldr_state_t : loader FSM state encoding
//   - xor8        : running checksum step over payload bytes
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    CHK,
    DONE,
    ERR
  } ldr_state_t;

  function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Byte stream from the host/UART source into the loader (valid/ready).
//   A byte moves on a clock edge where rx_valid and rx_ready are both high.
//   Ports (modports):
//     master : byte source  -> drives rx_data, rx_valid; observes rx_ready
//     slave  : loader       -> observes rx_data, rx_valid; drives rx_ready
// -----------------------------------------------------------------------------
interface imem_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the CPU instruction-memory port. Consumes a framed byte
//   stream  CNT_HI CNT_LO {W_HI W_LO}*N CHK, packs each byte pair into a 16-bit
//   word written to consecutive imem byte addresses starting at BASE_ADDR
//   (must be even), and holds the CPU in reset until a full image has been
//   loaded with a matching XOR checksum over the 2N payload bytes.
// Parameters
//   BASE_ADDR  byte address of the first word (even)
//   MAX_WORDS  largest accepted word count; larger header -> ERR
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   start          one-cycle pulse; starts a load from IDLE, DONE or ERR
//   rx             byte stream (slave side)
//   mem_addr       imem byte address of the current word
//   mem_wdata      imem write data
//   mem_we         one-cycle write strobe, one clock after the W_LO transfer
//   cpu_rst_n      CPU reset, released only while in DONE
//   busy           load in progress (header through checksum)
//   done / err     load verified / load failed (levels)
//   words_loaded   words written in the current load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 32768
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave rx,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_wdata,
  output logic         mem_we,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  words_loaded
);

  ldr_state_t  state, state_nxt;
  logic [15:0] cnt;      // header count, then words still to receive
  logic [7:0]  hi_byte;
  logic [7:0]  chk_acc;
  logic [15:0] addr;
  logic [15:0] wcount;
  logic [15:0] wdata;
  logic        we;

  logic        in_load;
  logic        xfer;
  logic        can_start;
  logic [15:0] hdr_n;

  assign in_load   = state inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK};
  assign xfer      = rx.rx_valid & in_load;
  // start is only honoured when no load is running; a start that coincides
  // with the CHK transfer therefore cannot disturb that load's verdict.
  assign can_start = start & (state inside {IDLE, DONE, ERR});
  // Full word count as it becomes known during the CNT_LO transfer.
  assign hdr_n     = {cnt[15:8], rx.rx_data};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (can_start) state_nxt = HDR_HI;
      HDR_HI:          if (xfer) state_nxt = HDR_LO;
      HDR_LO: if (xfer) begin
        if (hdr_n == 16'd0)                   state_nxt = CHK;
        else if (32'(hdr_n) > MAX_WORDS)      state_nxt = ERR;
        else                                  state_nxt = DATA_HI;
      end
      DATA_HI:         if (xfer) state_nxt = DATA_LO;
      DATA_LO:         if (xfer) state_nxt = (cnt == 16'd1) ? CHK : DATA_HI;
      CHK:             if (xfer) state_nxt = (xor8(chk_acc, rx.rx_data) == 8'h00) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_byte <= '0;
      chk_acc <= '0;
      addr    <= BASE_ADDR;
      wcount  <= '0;
      wdata   <= '0;
      we      <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= 1'b0;

      // Address and count advance after the strobe has been presented.
      if (we) begin
        addr   <= addr + 16'd2;
        wcount <= wcount + 16'd1;
      end

      if (can_start) begin
        cnt     <= '0;
        chk_acc <= '0;
        addr    <= BASE_ADDR;
        wcount  <= '0;
      end

      if (xfer) begin
        unique case (state)
          HDR_HI:  cnt[15:8] <= rx.rx_data;
          HDR_LO:  cnt[7:0]  <= rx.rx_data;
          DATA_HI: begin
            hi_byte <= rx.rx_data;
            chk_acc <= xor8(chk_acc, rx.rx_data);
          end
          DATA_LO: begin
            wdata   <= {hi_byte, rx.rx_data};
            we      <= 1'b1;
            cnt     <= cnt - 16'd1;
            chk_acc <= xor8(chk_acc, rx.rx_data);
          end
          default: ;
        endcase
      end
    end
  end

  assign rx.rx_ready   = in_load;
  assign busy          = in_load;
  assign done          = (state == DONE);
  assign err           = (state == ERR);
  assign cpu_rst_n     = (state == DONE);
  assign mem_addr      = addr;
  assign mem_wdata     = wdata;
  assign mem_we        = we;
  assign words_loaded  = wcount;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Two loaders share one byte stream: dut0 with default parameters, dut1 at
//   BASE_ADDR 16'hFFFE (address wrap) with MAX_WORDS 5 (oversize header).
//   The driver issues frames and queues the writes each loader must make;
//   per-loader monitors pop and compare every mem_we strobe, including the
//   clock in which it appears.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'hFFFE;
  localparam int          MAX0  = 32768;
  localparam int          MAX1  = 5;

  typedef logic [15:0] wq_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic [15:0] mem_addr0, mem_wdata0, words0;
  logic        mem_we0, cpu_rst_n0, busy0, done0, err0;
  logic [15:0] mem_addr1, mem_wdata1, words1;
  logic        mem_we1, cpu_rst_n1, busy1, done1, err1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  wr_t q0[$];
  wr_t q1[$];

  imem_loader_if if0 ();
  imem_loader_if if1 ();
  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid;

  imem_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(MAX0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(if0.slave),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
    .cpu_rst_n(cpu_rst_n0), .busy(busy0), .done(done0), .err(err0),
    .words_loaded(words0)
  );

  imem_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(MAX1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(if1.slave),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .cpu_rst_n(cpu_rst_n1), .busy(busy1), .done(done1), .err(err1),
    .words_loaded(words1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors (scoreboard side) ----------------
  always @(negedge clk) begin
    #1;
    if (mem_we0) begin
      check("dut0_write_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        wr_t e;
        e = q0.pop_front();
        check("dut0_mem_addr",  32'(mem_addr0),  32'(e.addr));
        check("dut0_mem_wdata", 32'(mem_wdata0), 32'(e.data));
        check("dut0_we_cycle",  32'(cyc),        32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (mem_we1) begin
      check("dut1_write_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        wr_t e;
        e = q1.pop_front();
        check("dut1_mem_addr",  32'(mem_addr1),  32'(e.addr));
        check("dut1_mem_wdata", 32'(mem_wdata1), 32'(e.data));
        check("dut1_we_cycle",  32'(cyc),        32'(e.cyc));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns the cycle count seen just before the
  // accepting edge; the resulting write strobe is due one clock later.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start,
                           output int stamp);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    start    = with_start;
    budget   = 0;
    while (!if0.rx_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check("rx_ready_within_budget", 32'(if0.rx_ready), 32'd1);
    stamp = cyc;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic expect_status(input int d, input bit e_done, input bit e_err,
                               input logic [15:0] e_words);
    if (d == 0) begin
      check("dut0_done",         32'(done0),      32'(e_done));
      check("dut0_err",          32'(err0),       32'(e_err));
      check("dut0_cpu_rst_n",    32'(cpu_rst_n0), 32'(e_done));
      check("dut0_busy",         32'(busy0),      32'd0);
      check("dut0_words_loaded", 32'(words0),     32'(e_words));
    end else begin
      check("dut1_done",         32'(done1),      32'(e_done));
      check("dut1_err",          32'(err1),       32'(e_err));
      check("dut1_cpu_rst_n",    32'(cpu_rst_n1), 32'(e_done));
      check("dut1_busy",         32'(busy1),      32'd0);
      check("dut1_words_loaded", 32'(words1),     32'(e_words));
    end
  endtask

  task automatic check_reset();
    check("rst_dut0_busy",      32'(busy0),       32'd0);
    check("rst_dut0_done",      32'(done0),       32'd0);
    check("rst_dut0_err",       32'(err0),        32'd0);
    check("rst_dut0_cpu_rst_n", 32'(cpu_rst_n0),  32'd0);
    check("rst_dut0_mem_we",    32'(mem_we0),     32'd0);
    check("rst_dut0_mem_addr",  32'(mem_addr0),   32'(BASE0));
    check("rst_dut0_words",     32'(words0),      32'd0);
    check("rst_dut0_rx_ready",  32'(if0.rx_ready), 32'd0);
    check("rst_dut1_mem_addr",  32'(mem_addr1),   32'(BASE1));
    check("rst_dut1_busy",      32'(busy1),       32'd0);
    check("rst_dut1_words",     32'(words1),      32'd0);
  endtask

  function automatic wq_t rand_words(input int n);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back(16'($urandom));
    return w;
  endfunction

  function automatic logic [7:0] payload_xor(input wq_t w);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x = x ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  // Reference behaviour of one frame for both loaders. stop_after >= 0 ends
  // the frame early after that many words (used for the mid-load reset).
  task automatic do_frame(input int n, input wq_t words, input logic [7:0] chk,
                          input bit gaps, input int stop_after);
    int  st;
    bit  ok0, ok1, good;
    ok0  = (n <= MAX0);
    ok1  = (n <= MAX1);
    good = (chk == payload_xor(words));
    pulse_start();
    send_byte(8'(n >> 8), gaps, 1'b0, st);
    send_byte(8'(n),      gaps, 1'b0, st);
    if (!ok0) begin
      expect_status(0, 1'b0, 1'b1, 16'd0);
      expect_status(1, 1'b0, 1'b1, 16'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i == stop_after) return;
      // A start while both loaders are mid-load must be ignored.
      if (ok1 && $urandom_range(0, 7) == 0) pulse_start();
      send_byte(words[i][15:8], gaps, 1'b0, st);
      send_byte(words[i][7:0],  gaps, 1'b0, st);
      q0.push_back('{addr: 16'(BASE0 + 16'(2 * i)), data: words[i], cyc: st + 1});
      if (ok1) q1.push_back('{addr: 16'(BASE1 + 16'(2 * i)), data: words[i], cyc: st + 1});
    end
    send_byte(chk, gaps, ok1 && ($urandom_range(0, 1) == 1), st);
    expect_status(0, good, !good, 16'(n));
    if (ok1) expect_status(1, good, !good, 16'(n));
    else     expect_status(1, 1'b0, 1'b1, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wq_t w;
    logic [7:0] x;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset();

    // Two-word image with a correct checksum.
    w = {16'hA123, 16'hB456};
    x = payload_xor(w);
    do_frame(2, w, x, 1'b0, -1);

    // DONE consumes nothing even with a byte pending.
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_holds_no_ready", 32'(if0.rx_ready), 32'd0);
    check("done_holds_done",     32'(done0),        32'd1);
    rx_valid = 1'b0;

    // Same image, wrong checksum: writes still issued, load fails.
    do_frame(2, w, x ^ 8'h01, 1'b1, -1);

    // Empty images.
    w = {};
    do_frame(0, w, 8'h00, 1'b0, -1);
    do_frame(0, w, 8'h7F, 1'b1, -1);

    // Oversized header for both loaders.
    do_frame(MAX0 + 1, w, 8'h00, 1'b0, -1);

    // Reset after 3 of 5 words, then a full reload from the base address.
    w = rand_words(5);
    do_frame(5, w, payload_xor(w), 1'b1, 3);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset();
    do_frame(5, w, payload_xor(w), 1'b0, -1);

    // Random frames, with and without idle gaps between bytes.
    for (int f = 0; f < 14; f++) begin
      int  n;
      bit  bad;
      n   = $urandom_range(0, 6);
      bad = ($urandom_range(0, 3) == 0);
      w   = rand_words(n);
      x   = payload_xor(w);
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      do_frame(n, w, x, f[0], -1);
    end

    repeat (4) @(negedge clk);
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
